// File: rtl/seq_dec_sched.sv
// ---------------------------------------------------------------------------
// seq_dec_sched
//   Round-robin scheduler feeding one shared "run of 1s" detector from NCH
//   serial channels. Each cycle at most one requesting channel is granted,
//   searching upward from a rotating pointer. The granted bit is consumed on
//   that edge and advances (or clears) that channel's private run counter.
//   A completed run raises a registered one-cycle match pulse with the
//   channel index.
//
// Handshake: req[i]/in[i] form a valid/ready pair with ack[i] as ready. A
//   bit transfers on a rising edge where req[i]=1 and ack[i]=1. A channel
//   that is not acked must keep req[i] and in[i] stable. ack is
//   combinational, one-hot or zero, and is forced to zero while rst=0.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-low reset
//   req[NCH]  per-channel request (in[i] holds a valid bit)
//   in[NCH]   per-channel serial data bit
//   ovl       1 = overlapping detection, 0 = non-overlapping
//   ack[NCH]  one-hot grant, combinational
//   match     registered one-cycle pulse when a run completes
//   match_ch  index of the matching channel (holds between matches)
//
// Optional feature (macro SEQ_DEC_SCHED_CNT_EN):
//   cnt_sel[CW]  selects a per-channel match counter
//   cnt_out[8]   combinational value of the selected saturating counter
// ---------------------------------------------------------------------------
module seq_dec_sched #(
    parameter int NCH     = 4,
    parameter int RUN_LEN = 3,
    parameter int CW      = $clog2(NCH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] req,
    input  logic [NCH-1:0] in,
    input  logic           ovl,
    output logic [NCH-1:0] ack,
    output logic           match,
    output logic [CW-1:0]  match_ch
`ifdef SEQ_DEC_SCHED_CNT_EN
    ,
    input  logic [CW-1:0]  cnt_sel,
    output logic [7:0]     cnt_out
`endif
);

    // Run counter only needs to reach RUN_LEN-1; keep at least one bit.
    localparam int              CNTW    = (RUN_LEN > 1) ? $clog2(RUN_LEN) : 1;
    localparam logic [CNTW-1:0] CNT_TOP = CNTW'(RUN_LEN - 1);
    localparam logic [CW-1:0]   LAST_CH = CW'(NCH - 1);

    logic [CW-1:0]   ptr_q, ptr_d;
    logic [CNTW-1:0] cnt_q [NCH];
    logic [CNTW-1:0] cnt_d [NCH];
    logic            match_q, match_d;
    logic [CW-1:0]   match_ch_q, match_ch_d;

    logic            grant_vld;
    logic [CW-1:0]   grant_idx;

    // Arbiter: first requester at or above ptr, wrapping modulo NCH.
    always_comb begin
        int unsigned   idx;
        logic [CW-1:0] sel;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        sel       = '0;
        for (int k = 0; k < NCH; k++) begin
            idx = (int'(ptr_q) + k) % NCH;
            sel = CW'(idx);
            if (!grant_vld && req[sel]) begin
                grant_vld = 1'b1;
                grant_idx = sel;
            end
        end
    end

    // Grant is suppressed during reset so nothing is consumed.
    always_comb begin
        ack = '0;
        if (rst && grant_vld) begin
            ack[grant_idx] = 1'b1;
        end
    end

    // Pointer and run-counter update for the granted channel only; every
    // other channel's counter is left untouched.
    always_comb begin
        ptr_d      = ptr_q;
        match_d    = 1'b0;
        match_ch_d = match_ch_q;
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        if (grant_vld) begin
            ptr_d = (grant_idx == LAST_CH) ? '0 : grant_idx + 1'b1;
            if (!in[grant_idx]) begin
                cnt_d[grant_idx] = '0;
            end else if (cnt_q[grant_idx] != CNT_TOP) begin
                cnt_d[grant_idx] = cnt_q[grant_idx] + 1'b1;
            end else begin
                // Run complete. Overlap keeps the counter at the top so the
                // next 1 completes another run; non-overlap starts fresh.
                match_d    = 1'b1;
                match_ch_d = grant_idx;
                if (!ovl) begin
                    cnt_d[grant_idx] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q      <= '0;
            match_q    <= 1'b0;
            match_ch_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            ptr_q      <= ptr_d;
            match_q    <= match_d;
            match_ch_q <= match_ch_d;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign match    = match_q;
    assign match_ch = match_ch_q;

`ifdef SEQ_DEC_SCHED_CNT_EN
    logic [7:0] mcnt_q [NCH];
    logic [7:0] mcnt_d [NCH];

    // Saturating per-channel match counters; they stick at 255.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            mcnt_d[i] = mcnt_q[i];
        end
        if (match_d && (mcnt_q[match_ch_d] != 8'hFF)) begin
            mcnt_d[match_ch_d] = mcnt_q[match_ch_d] + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NCH; i++) begin
                mcnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                mcnt_q[i] <= mcnt_d[i];
            end
        end
    end

    // Out-of-range selects (non power-of-two NCH) read as zero.
    always_comb begin
        cnt_out = '0;
        if (int'(cnt_sel) < NCH) begin
            cnt_out = mcnt_q[cnt_sel];
        end
    end
`endif

endmodule

// File: tb/tb_seq_dec_sched.sv
// ---------------------------------------------------------------------------
// tb_seq_dec_sched
//   Bench for seq_dec_sched with NCH=4, RUN_LEN=3. drive_cycle applies one
//   cycle of stimulus, advances a reference model of the pointer and run
//   counters, and pushes the expected ack and the expected {match, match_ch}
//   into queues. The scoreboard pops and compares them on the falling edge.
//   Scenario tasks additionally compare observed values against fixed
//   expectations for each directed case.
// ---------------------------------------------------------------------------
module tb_seq_dec_sched;

    localparam int NCH     = 4;
    localparam int RUN_LEN = 3;
    localparam int CW      = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [NCH-1:0] req;
    logic [NCH-1:0] in;
    logic           ovl;
    logic [NCH-1:0] ack;
    logic           match;
    logic [CW-1:0]  match_ch;
`ifdef SEQ_DEC_SCHED_CNT_EN
    logic [CW-1:0]  cnt_sel;
    logic [7:0]     cnt_out;
`endif

    seq_dec_sched #(.NCH(NCH), .RUN_LEN(RUN_LEN), .CW(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .in       (in),
        .ovl      (ovl),
        .ack      (ack),
        .match    (match),
        .match_ch (match_ch)
`ifdef SEQ_DEC_SCHED_CNT_EN
        ,
        .cnt_sel  (cnt_sel),
        .cnt_out  (cnt_out)
`endif
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int tests_run    = 0;
    int tests_failed = 0;

    logic [NCH-1:0] exp_ack_q[$];
    logic [CW:0]    exp_q[$];   // {match, match_ch}

    // Reference model state
    int            m_ptr;
    int            m_cnt  [NCH];
    int            m_mcnt [NCH];
    logic [CW-1:0] m_mch;

    // Values observed by the latest drive_cycle
    logic [NCH-1:0] obs_ack;
    logic           obs_m;
    logic [CW-1:0]  obs_ch;

    // ---------------- driver ----------------
    task automatic drive_cycle(input logic [NCH-1:0] r, input logic [NCH-1:0] d,
                               input logic o, input logic rs);
        logic [NCH-1:0] ea;
        logic           em;
        int             g;
        int             idx;
        req = r;
        in  = d;
        ovl = o;
        rst = rs;
        ea  = '0;
        em  = 1'b0;
        g   = -1;
        if (rs) begin
            for (int k = 0; k < NCH; k++) begin
                idx = (m_ptr + k) % NCH;
                if (g < 0 && r[CW'(idx)]) g = idx;
            end
        end
        if (g >= 0) ea[CW'(g)] = 1'b1;
        exp_ack_q.push_back(ea);
        if (!rs) begin
            m_ptr = 0;
            m_mch = '0;
            for (int i = 0; i < NCH; i++) begin
                m_cnt[i]  = 0;
                m_mcnt[i] = 0;
            end
        end else if (g >= 0) begin
            m_ptr = (g + 1) % NCH;
            if (!d[CW'(g)]) begin
                m_cnt[g] = 0;
            end else if (m_cnt[g] < RUN_LEN - 1) begin
                m_cnt[g] = m_cnt[g] + 1;
            end else begin
                em    = 1'b1;
                m_mch = CW'(g);
                if (!o) m_cnt[g] = 0;
                if (m_mcnt[g] < 255) m_mcnt[g] = m_mcnt[g] + 1;
            end
        end
        @(negedge clk);
        obs_ack = ack;
        @(posedge clk);
        #1;
        exp_q.push_back({em, m_mch});
        obs_m  = match;
        obs_ch = match_ch;
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        logic [NCH-1:0] ea;
        logic [CW:0]    e;
        if (exp_ack_q.size() > 0) begin
            ea = exp_ack_q.pop_front();
            tests_run++;
            if (ack !== ea) begin
                tests_failed++;
                $display("FAIL sb_ack t=%0t got=%b exp=%b", $time, ack, ea);
            end
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            if (match !== e[CW] || match_ch !== e[CW-1:0]) begin
                tests_failed++;
                $display("FAIL sb_match t=%0t got=%b/%0d exp=%b/%0d",
                         $time, match, match_ch, e[CW], e[CW-1:0]);
            end
        end
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive_cycle(4'b1111, 4'b1111, 1'b1, 1'b0);
            tests_run++;
            if (obs_ack !== 4'b0000 || obs_m !== 1'b0 || obs_ch !== 2'd0) begin
                tests_failed++;
                $display("FAIL reset_state ack=%b match=%b ch=%0d exp 0000/0/0",
                         obs_ack, obs_m, obs_ch);
            end
        end
`ifdef SEQ_DEC_SCHED_CNT_EN
        for (int s = 0; s < NCH; s++) begin
            cnt_sel = CW'(s);
            #1;
            tests_run++;
            if (cnt_out !== 8'd0) begin
                tests_failed++;
                $display("FAIL reset_cnt sel=%0d got=%0d exp=0", s, cnt_out);
            end
        end
        cnt_sel = '0;
`endif
    endtask

    task automatic test_overlap();
        logic [5:0] bits = 6'b111110;   // bit0 first: 0,1,1,1,1,1
        logic [5:0] exp  = 6'b111000;
        for (int i = 0; i < 6; i++) begin
            drive_cycle(4'b0001, {3'b000, bits[i]}, 1'b1, 1'b1);
            tests_run++;
            if (obs_ack !== 4'b0001 || obs_m !== exp[i] ||
                (exp[i] && obs_ch !== 2'd0)) begin
                tests_failed++;
                $display("FAIL overlap bit%0d ack=%b match=%b ch=%0d exp 0001/%b/0",
                         i, obs_ack, obs_m, obs_ch, exp[i]);
            end
        end
    endtask

    task automatic test_non_overlap();
        logic [5:0] exp = 6'b100100;
        drive_cycle(4'b0001, 4'b0000, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            drive_cycle(4'b0001, 4'b0001, 1'b0, 1'b1);
            tests_run++;
            if (obs_m !== exp[i] || (exp[i] && obs_ch !== 2'd0)) begin
                tests_failed++;
                $display("FAIL non_overlap bit%0d match=%b ch=%0d exp %b/0",
                         i, obs_m, obs_ch, exp[i]);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [NCH-1:0] ea;
        logic           em;
        drive_cycle(4'b0000, 4'b0000, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            drive_cycle(4'b1111, 4'b1111, 1'b1, 1'b1);
            ea = 4'b0001 << (i % 4);
            em = (i >= 8);
            tests_run++;
            if (obs_ack !== ea || obs_m !== em || (em && obs_ch !== CW'(i % 4))) begin
                tests_failed++;
                $display("FAIL round_robin cyc%0d ack=%b match=%b ch=%0d exp %b/%b/%0d",
                         i + 1, obs_ack, obs_m, obs_ch, ea, em, i % 4);
            end
        end
    endtask

    task automatic test_interleave();
        logic [NCH-1:0] r_seq [5] = '{4'b0010, 4'b0010, 4'b0100, 4'b0010, 4'b0010};
        logic [NCH-1:0] d_seq [5] = '{4'b0000, 4'b0010, 4'b0000, 4'b0010, 4'b0010};
        for (int i = 0; i < 5; i++) begin
            drive_cycle(r_seq[i], d_seq[i], 1'b0, 1'b1);
            tests_run++;
            if (obs_m !== (i == 4) || (i == 4 && obs_ch !== 2'd1)) begin
                tests_failed++;
                $display("FAIL interleave step%0d match=%b ch=%0d exp %b/1",
                         i, obs_m, obs_ch, (i == 4));
            end
        end
    endtask

    task automatic test_reset_mid_run();
        drive_cycle(4'b0001, 4'b0000, 1'b0, 1'b1);
        drive_cycle(4'b0001, 4'b0001, 1'b0, 1'b1);
        drive_cycle(4'b0001, 4'b0001, 1'b0, 1'b1);
        drive_cycle(4'b0001, 4'b0001, 1'b0, 1'b0);
        tests_run++;
        if (obs_ack !== 4'b0000 || obs_m !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_run_hold ack=%b match=%b exp 0000/0", obs_ack, obs_m);
        end
        for (int i = 0; i < 3; i++) begin
            drive_cycle(4'b0001, 4'b0001, 1'b0, 1'b1);
            tests_run++;
            if (obs_m !== (i == 2)) begin
                tests_failed++;
                $display("FAIL reset_mid_run bit%0d match=%b exp %b", i, obs_m, (i == 2));
            end
        end
    endtask

    task automatic test_random();
        logic rs;
        for (int i = 0; i < 250; i++) begin
            rs = ($urandom_range(0, 40) != 0);
            drive_cycle(NCH'($urandom_range(0, 15)), NCH'($urandom_range(0, 15)),
                        1'($urandom_range(0, 1)), rs);
        end
`ifdef SEQ_DEC_SCHED_CNT_EN
        for (int s = 0; s < NCH; s++) begin
            cnt_sel = CW'(s);
            #1;
            tests_run++;
            if (cnt_out !== 8'(m_mcnt[s])) begin
                tests_failed++;
                $display("FAIL random_cnt sel=%0d got=%0d exp=%0d", s, cnt_out, m_mcnt[s]);
            end
        end
        cnt_sel = '0;
`endif
    endtask

`ifdef SEQ_DEC_SCHED_CNT_EN
    task automatic test_counters();
        drive_cycle(4'b0000, 4'b0000, 1'b1, 1'b0);
        for (int i = 0; i < 302; i++) begin
            drive_cycle(4'b1000, 4'b1000, 1'b1, 1'b1);
        end
        cnt_sel = 2'd3;
        #1;
        tests_run++;
        if (cnt_out !== 8'd255) begin
            tests_failed++;
            $display("FAIL cnt_sat sel=3 got=%0d exp=255", cnt_out);
        end
        cnt_sel = 2'd0;
        #1;
        tests_run++;
        if (cnt_out !== 8'd0) begin
            tests_failed++;
            $display("FAIL cnt_other sel=0 got=%0d exp=0", cnt_out);
        end
    endtask
`endif

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b0;
        req = '0;
        in  = '0;
        ovl = 1'b0;
        m_ptr = 0;
        m_mch = '0;
        for (int i = 0; i < NCH; i++) begin
            m_cnt[i]  = 0;
            m_mcnt[i] = 0;
        end
`ifdef SEQ_DEC_SCHED_CNT_EN
        cnt_sel = '0;
`endif
        @(posedge clk);
        #1;
        test_reset();
        test_overlap();
        test_non_overlap();
        test_round_robin();
        test_interleave();
        test_reset_mid_run();
        test_random();
`ifdef SEQ_DEC_SCHED_CNT_EN
        test_counters();
`endif
        drive_cycle(4'b0000, 4'b0000, 1'b0, 1'b1);
        @(negedge clk);
        #1;
        tests_run++;
        if (exp_q.size() != 0 || exp_ack_q.size() != 0) begin
            tests_failed++;
            $display("FAIL sb_drain left=%0d/%0d exp 0/0", exp_q.size(), exp_ack_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
